// File: rtl/aes256_encr_stream.sv
// Iterative AES-256 block encryptor computing RPC rounds per clock, with valid/ready on both sides.
// The key is captured with every block, and a sideband tag travels with the block to the output.
module aes256_encr_stream #(
    parameter int unsigned RPC   = 1,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [255:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Round index presented to the first unit on the finishing edge.
    localparam logic [3:0] LAST_RND = 4'(15 - RPC);

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 7 || RPC == 14)) begin : g_bad_rpc
            $error("aes256_encr_stream: RPC must be 1, 2, 7 or 14");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("aes256_encr_stream: TAG_W must be at least 1");
        end
    endgenerate

    // Entry b is stored at index 255-b, so the lookup index is ~b.
    localparam logic [255:0][7:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = SBOX_TAB[~w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int unsigned i = 0; i < 16; i++) r[8*i +: 8] = SBOX_TAB[~s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned w = 0; w < 4; w++) begin
                r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(shift_rows(sub_bytes(s))) ^ k;
    endfunction

    function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] k);
        return shift_rows(sub_bytes(s)) ^ k;
    endfunction

    // All fifteen round keys, round 0 in the top 128 bits.
    function automatic logic [1919:0] key_expand(input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] rk;
        rc = 8'h01;
        for (int unsigned i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int unsigned i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int unsigned i = 0; i < 60; i++) rk[1919 - 32*i -: 32] = w[i];
        return rk;
    endfunction

    state_t           r_fsm;
    state_t           w_fsm_nxt;
    logic [127:0]     r_state;
    logic [255:0]     r_key;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_rnd;
    logic [1919:0]    w_rkeys;
    logic [127:0]     w_rk [15];
    logic [127:0]     w_chain;
    logic [3:0]       w_idx;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_rnd == LAST_RND);

    always_comb begin
        w_rkeys = key_expand(r_key);
        for (int unsigned i = 0; i < 15; i++) w_rk[i] = w_rkeys[1919 - 128*i -: 128];
    end

    // Only the final unit of the chain can land on round 14, so only it carries the no-MixColumns variant.
    always_comb begin
        w_chain = r_state;
        w_idx   = '0;
        for (int unsigned j = 0; j < RPC; j++) begin
            w_idx = 4'(r_rnd + j);
            if (j == RPC - 1 && w_idx == 4'd14) w_chain = final_round(w_chain, w_rk[w_idx]);
            else                                w_chain = encrypt_round(w_chain, w_rk[w_idx]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) w_fsm_nxt = S_FULL;
            end
            S_FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_fsm_nxt = in_valid ? S_BUSY : S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= '0;
            r_key    <= '0;
            r_tag    <= '0;
            r_rnd    <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (w_accept) begin
            r_state <= in_data ^ in_key[255:128];
            r_key   <= in_key;
            r_tag   <= in_tag;
            r_rnd   <= 4'd1;
        end else if (busy) begin
            if (w_last) begin
                out_data <= w_chain;
                out_tag  <= r_tag;
                r_rnd    <= '0;
            end else begin
                r_state <= w_chain;
                r_rnd   <= r_rnd + 4'(RPC);
            end
        end
    end

endmodule

// File: tb/tb_aes256_encr_stream.sv
// Bench for aes256_encr_stream: four instances (RPC 1/2/7/14) share stimulus; RPC=1 is scoreboarded
// against a byte-oriented reference built from a computed S-box.
module tb_aes256_encr_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [255:0] in_key = '0;
    logic [7:0]   in_tag = '0;
    logic         ir [4];
    logic         ov [4];
    logic         bs [4];
    logic [127:0] od [4];
    logic [7:0]   ot [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned R = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 7 : 14;
        aes256_encr_stream #(.RPC(R), .TAG_W(8)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
            .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .out_tag(ot[g]), .busy(bs[g])
        );
    end

    function automatic int rpc_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 7 : 14;
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key);
        logic [7:0]   w [240];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x;
        logic [127:0] res;
        for (int i = 0; i < 32; i++) w[i] = key[255 - 8*i -: 8];
        rc = 8'h01;
        for (int i = 32; i < 240; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 32 == 0) begin
                x = tmp[0];
                tmp[0] = sb_tab[tmp[1]] ^ rc;
                tmp[1] = sb_tab[tmp[2]];
                tmp[2] = sb_tab[tmp[3]];
                tmp[3] = sb_tab[x];
                rc = gmul(rc, 8'h02);
            end else if (i % 32 == 16) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb_tab[tmp[j]];
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 32 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 14) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Scoreboard on the RPC=1 instance, sampled mid-cycle
    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   tag;
    } exp_t;

    exp_t sb [$];
    int   cyc = 0;
    int   last_acc = -1;
    int   n_acc = 0;
    int   n_drain = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            last_acc = -1;
            n_acc    = 0;
            n_drain  = 0;
        end else begin
            if (ov[0] && out_ready) begin
                n_drain++;
                if (sb.size() == 0) check("sb_spurious", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_data", od[0], e.data);
                    check("sb_tag", ot[0], e.tag);
                end
            end
            if (in_valid && ir[0]) begin
                if (last_acc >= 0) check("period_ge_15", (cyc - last_acc) >= 15, 1);
                last_acc = cyc;
                n_acc++;
                e.data = aes_ref(in_data, in_key);
                e.tag  = in_tag;
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, input int n);
        int i;
        i = 0;
        while (!ov[0] && i < n) begin
            tick();
            i++;
        end
        check(tag, ov[0], 1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    // Known-answer run on all four instances at once: latency, data, tag, pulse width
    task automatic kat(input string name, input logic [127:0] pt, input logic [255:0] key,
                       input logic [7:0] tag, input logic [127:0] ct);
        int           lat [4];
        logic [127:0] d [4];
        logic [7:0]   tg [4];
        int           vcnt;
        out_ready = 1'b1;
        in_data   = pt;
        in_key    = key;
        in_tag    = tag;
        in_valid  = 1'b1;
        #1;
        check({name, "_all_ready"}, ir[0] && ir[1] && ir[2] && ir[3], 1);
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
        in_key   = rnd256();
        vcnt     = 0;
        for (int g = 0; g < 4; g++) begin
            lat[g] = 0;
            d[g]   = '0;
            tg[g]  = '0;
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                if (ov[g] && lat[g] == 0) begin
                    lat[g] = k;
                    d[g]   = od[g];
                    tg[g]  = ot[g];
                end
            end
            if (ov[0]) vcnt++;
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("%s_lat_rpc%0d", name, rpc_of(g)), lat[g], 14 / rpc_of(g));
            check($sformatf("%s_data_rpc%0d", name, rpc_of(g)), d[g], ct);
            check($sformatf("%s_tag_rpc%0d", name, rpc_of(g)), tg[g], tag);
        end
        check({name, "_valid_width"}, vcnt, 1);
    endtask

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] F_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] F_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] F_CT   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] hold;
        logic         acc;
        int           sent, budget, vc;

        build_sbox();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", ov[0], 0);
        check("rst_busy", bs[0], 0);
        check("rst_out_data", od[0], 0);
        check("rst_out_tag", ot[0], 0);
        check("rst_in_ready", ir[0], 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        kat("c3", C3_PT, C3_KEY, 8'h5a, C3_CT);
        kat("f15", F_PT, F_KEY, 8'ha7, F_CT);

        // Inputs scrambled every cycle while busy
        in_data  = rnd128();
        in_key   = rnd256();
        in_tag   = 8'h3c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_data = rnd128();
            in_key  = rnd256();
            in_tag  = 8'($urandom);
            tick();
        end
        wait_out("iso_out", 5);
        tick();

        // Backpressure with a second block waiting
        out_ready = 1'b0;
        in_data   = rnd128();
        in_key    = rnd256();
        in_tag    = 8'hb1;
        in_valid  = 1'b1;
        tick();
        in_data = rnd128();
        in_key  = rnd256();
        in_tag  = 8'hb2;
        wait_out("bp_out", 20);
        hold = od[0];
        for (int i = 0; i < 20; i++) begin
            check("bp_data_stable", od[0], hold);
            check("bp_in_ready_low", ir[0], 0);
            check("bp_valid_held", ov[0], 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", ir[0], 1);
        tick();
        in_valid = 1'b0;
        check("bp_accept2_busy", bs[0], 1);
        check("bp_drain1_valid", ov[0], 0);
        wait_out("bp_out2", 20);
        for (int i = 0; i < 20; i++) tick();

        // Reset in the middle of a block
        in_data  = C3_PT;
        in_key   = C3_KEY;
        in_tag   = 8'h77;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", bs[0], 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", ov[0], 0);
        check("mid_rst_busy", bs[0], 0);
        check("mid_rst_out_data", od[0], 0);
        check("mid_rst_out_tag", ot[0], 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", ir[0], 1);
        vc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov[0]) vc++;
        end
        check("mid_rst_no_valid", vc, 0);
        kat("c3_after_rst", C3_PT, C3_KEY, 8'h5a, C3_CT);

        // Random streaming with random handshakes
        sent   = 0;
        budget = 0;
        while (sent < 100 && budget < 20000) begin
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = rnd128();
                in_key   = rnd256();
                in_tag   = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && ir[0];
            tick();
            budget++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        check("stream_sent", sent, 100);
        check("stream_drained", sb.size(), 0);
        check("stream_in_out_count", n_drain, n_acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aes256_encr_stream.md
# aes256_encr_stream

Parametrised iterative AES-256 block encryptor with valid/ready streaming handshakes on both sides. It processes RPC rounds per clock, so the same RTL trades area for latency. The key is captured per block, and a sideband tag travels with each block. It sits between the GCM counter-block generator and the keystream XOR/GHASH path, reusing the team's keyexpan, encryptRound, subbyte, shiftrow and addroundkey modules.

## Interface
- RPC, default 1: rounds computed per clock. Legal values are 1, 2, 7, 14; any other value is an elaboration error.
- TAG_W, default 8: width of the sideband tag carried with each block. Minimum 1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block and key are valid.
- in_ready  out  1  block can accept; combinational, equal to !busy && (!out_valid || out_ready).
- in_data  in  128  plaintext block, FIPS-197 byte order with byte 0 in [127:120].
- in_key  in  256  AES-256 key, byte 0 in [255:248].
- in_tag  in  TAG_W  sideband value, returned unchanged with the result.
- out_valid  out  1  out_data/out_tag hold a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  ciphertext.
- out_tag  out  TAG_W  tag of the block in out_data.
- busy  out  1  round iteration in progress.

## Operation
- ITER = 14/RPC iteration cycles per block: 14, 7, 2 or 1.
- **Accept** happens at an edge with in_valid && in_ready.
  - state_reg <= in_data ^ in_key[255:128], which is AddRoundKey with K0.
  - key_reg <= in_key; tag_reg <= in_tag; rnd <= 1; busy <= 1.
- **Key expansion** runs combinationally from key_reg through keyexpan. Round r uses roundKeys[1919-128*r -: 128].
- **Iteration**: each busy edge chains RPC round units over rounds rnd .. rnd+RPC-1.
  - Units for rounds 1..13 apply the full round (encryptRound).
  - The unit for round 14 applies SubBytes, ShiftRows, then AddRoundKey with K14, with no MixColumns.
  - Round 14 is always the last unit of the last iteration.
  - After the edge, rnd <= rnd + RPC.
- **Finish**: the edge that completes round 14 does the following.
  - out_data <= result; out_tag <= tag_reg.
  - out_valid <= 1; busy <= 0; rnd <= 0.
- **Output hold**: out_valid, out_data and out_tag stay stable until an edge with out_valid && out_ready.
  - At that edge, out_valid <= 0 unless a new result is written at the same edge. This cannot happen, because busy and out_valid are never both 1.
- **Simultaneous drain and accept**: with out_valid=1, out_ready=1 and in_valid=1, the output is consumed and the new block is accepted at the same edge. in_ready is high via the out_ready term.
- **Input changes while busy**: in_key, in_data and in_tag may change freely while busy. Only the values present at the accept edge are used.
- in_valid is never dropped by this block. Inputs presented while in_ready=0 are ignored.
- **Reset**, asynchronous and at any time, including mid-block:
  - busy=0, out_valid=0, out_data=0, out_tag=0, rnd=0, state_reg=0, key_reg=0, tag_reg=0.
  - Any in-flight block is discarded with no output.
  - in_ready=1 immediately after reset.

## Timing
- Accept at edge E0; busy=1 from E0 through E_ITER.
- out_valid rises after edge E_ITER.
  - RPC=1: 14 cycles from accept.
  - RPC=14: 1 cycle.
- Minimum block period with out_ready held high is ITER+1 cycles: E_ITER sets out_valid, then E_ITER+1 drains it and accepts the next block.
- If out_ready is low, the result holds indefinitely and in_ready stays 0.
- Critical path is keyexpan (from key_reg) plus RPC chained rounds. RPC=14 is intended only for low-frequency targets.

## Test plan
- **FIPS-197 C.3, RPC=1**: key 000102…1f, pt 00112233445566778899aabbccddeeff, tag 8'h5A, out_ready=1.
  - Required: out_data=8ea2b7ca516745bfeafc49904b496089, out_tag=5A.
  - out_valid first high 14 cycles after accept, for exactly 1 cycle.
- **SP800-38A F.1.5, RPC ∈ {2,7,14}**:
  - key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, pt 6bc1bee22e409f96e93d7e117393172a.
  - Required: ct f3eed1bdb5d2a03c064b5a7e3db181f8.
  - Latency 7, 2 and 1 cycles respectively.
- **Backpressure**: out_ready=0 for 20 cycles after out_valid rises, with in_valid=1 and a second block waiting.
  - out_data stable and in_ready=0 throughout.
  - Raising out_ready drains block 1 and accepts block 2 on the same edge.
  - Block 2 result is correct, with its own tag.
- **Input-change isolation**: change in_key/in_data to random values every cycle while busy.
  - Required: result equals the encryption of the values present at the accept edge.
- **Reset mid-block**: assert rst at round 6 (RPC=1).
  - Required: out_valid, busy and out_data go to 0 immediately; in_ready=1 after release.
  - No spurious out_valid afterwards.
  - A fresh C.3 block then encrypts correctly.
- **Streaming**: 100 random blocks and keys with random in_valid/out_ready, checked against a reference model.
  - Required: in-order results with tags preserved; no lost or duplicated blocks.
  - Period ≥ ITER+1 cycles.
